paddle_unit: RTL and testbench



---
 rtl/paddle_unit.sv | 96 +++++++++
 tb/tb_paddle_unit.sv | 119 +++++++++++
 2 files changed

// File: rtl/paddle_unit.sv
// paddle_unit: frame-rate paddle position with speed ramp and clamping,
// plus a registered pixel renderer against the VGA counters.
module paddle_unit #(
    parameter logic [7:0] PADDLE_COLOR      = 8'hFF,
    parameter int         PADDLE_CENTER_COL = 15,
    parameter int         PADDLE_HEIGHT     = 44,
    parameter int         PADDLE_WIDTH      = 14,
    parameter int         RESET_ROW         = 240,
    parameter int         TOP_LIMIT         = 0,
    parameter int         BOTTOM_LIMIT      = 479,
    parameter int         MIN_SPEED         = 2,
    parameter int         MAX_SPEED         = 8,
    parameter int         ACCEL_FRAMES      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        move_up_control,
    input  logic        move_down_control,
    input  logic [11:0] col_counter,
    input  logic [11:0] row_counter,
    output logic [11:0] paddle_center_row,
    output logic [7:0]  paddle_rgb,
    output logic        at_top,
    output logic        at_bottom
);
    localparam int SW = $clog2(MAX_SPEED + 1);
    localparam int CW = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    localparam logic [12:0] MIN_C  = 13'(TOP_LIMIT + PADDLE_HEIGHT / 2);
    localparam logic [12:0] MAX_C  = 13'(BOTTOM_LIMIT - PADDLE_HEIGHT / 2);
    localparam logic [12:0] HALF_H = 13'(PADDLE_HEIGHT / 2);
    localparam logic [11:0] COL_LO = 12'(PADDLE_CENTER_COL - PADDLE_WIDTH / 2);
    localparam logic [11:0] COL_HI = 12'(PADDLE_CENTER_COL + PADDLE_WIDTH / 2);

    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    state_t          state_q, state_d, dir;
    logic [11:0]     centre_q, centre_d;
    logic [SW-1:0]   speed_q, speed_d, spd;
    logic [CW-1:0]   cnt_q, cnt_d, cnt;
    logic [7:0]      rgb_q, rgb_d;
    logic [12:0]     c13, s13, r13;
    logic            fresh, hit;

    always_comb begin
        dir = (move_up_control && !move_down_control) ? UP :
              (move_down_control && !move_up_control) ? DOWN : IDLE;
        // A new or idle direction starts over at the minimum speed.
        fresh = dir != state_q;
        spd = fresh ? SW'(MIN_SPEED) : speed_q;
        cnt = fresh ? '0 : cnt_q;
        c13 = {1'b0, centre_q};
        s13 = 13'(spd);
        state_d = state_q;
        centre_d = centre_q;
        speed_d = speed_q;
        cnt_d = cnt_q;
        if (frame_tick) begin
            state_d = dir;
            centre_d = (dir == UP)   ? ((c13 < MIN_C + s13) ? MIN_C[11:0] : 12'(c13 - s13)) :
                       (dir == DOWN) ? ((c13 + s13 > MAX_C) ? MAX_C[11:0] : 12'(c13 + s13)) :
                       centre_q;
            speed_d = spd;
            cnt_d = cnt;
            if (dir != IDLE) begin
                cnt_d = (cnt == CW'(ACCEL_FRAMES - 1)) ? '0 : cnt + 1'b1;
                speed_d = (cnt == CW'(ACCEL_FRAMES - 1) && spd < SW'(MAX_SPEED)) ? spd + 1'b1 : spd;
            end
        end
        r13 = {1'b0, row_counter};
        hit = (r13 + HALF_H >= c13) && (r13 <= c13 + HALF_H) &&
              (col_counter >= COL_LO) && (col_counter <= COL_HI);
        rgb_d = hit ? PADDLE_COLOR : 8'h00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            centre_q <= 12'(RESET_ROW);
            speed_q  <= SW'(MIN_SPEED);
            cnt_q    <= '0;
            rgb_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            centre_q <= centre_d;
            speed_q  <= speed_d;
            cnt_q    <= cnt_d;
            rgb_q    <= rgb_d;
        end
    end

    assign paddle_center_row = centre_q;
    assign paddle_rgb        = rgb_q;
    assign at_top            = {1'b0, centre_q} == MIN_C;
    assign at_bottom         = {1'b0, centre_q} == MAX_C;
endmodule

// File: tb/tb_paddle_unit.sv
// tb_paddle_unit: directed vectors with hand-computed centre, flag and pixel values.
module tb_paddle_unit;
    logic        clk = 0, reset = 0, frame_tick = 0, up = 0, dn = 0;
    logic [11:0] col = 0, row = 0;
    logic [11:0] centre;
    logic [7:0]  rgb;
    logic        at_top, at_bottom;
    int          errs = 0, checks = 0;

    paddle_unit dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .move_up_control(up), .move_down_control(dn),
        .col_counter(col), .row_counter(row),
        .paddle_center_row(centre), .paddle_rgb(rgb),
        .at_top(at_top), .at_bottom(at_bottom)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1;
        @(negedge clk) reset = 0;
    endtask

    task automatic tick(input logic u, input logic d);
        @(negedge clk) begin up = u; dn = d; frame_tick = 1; end
        @(negedge clk) frame_tick = 0;
    endtask

    task automatic pix(input logic [11:0] c, input logic [11:0] r, input logic [7:0] exp, input string tag);
        @(negedge clk) begin col = c; row = r; end
        @(negedge clk) chk(tag, 16'(rgb), 16'(exp));
    endtask

    initial begin
        int seq5 [5] = '{238, 236, 234, 232, 229};
        do_reset();
        repeat (2) @(negedge clk);
        chk("rst_centre", 16'(centre), 16'd240);
        chk("rst_rgb", 16'(rgb), 16'd0);
        chk("rst_top", 16'(at_top), 16'd0);
        chk("rst_bot", 16'(at_bottom), 16'd0);

        for (int i = 0; i < 5; i++) begin
            tick(1, 0);
            chk($sformatf("up5_%0d", i), 16'(centre), 16'(seq5[i]));
        end
        for (int i = 0; i < 3; i++) begin
            tick(1, 1);
            chk($sformatf("both_%0d", i), 16'(centre), 16'd229);
        end
        tick(1, 0);
        chk("after_both", 16'(centre), 16'd227);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) begin up = i[0]; dn = ~i[0]; end
        end
        @(negedge clk);
        chk("no_tick", 16'(centre), 16'd227);

        do_reset();
        for (int i = 0; i < 4; i++) tick(1, 0);
        chk("up4", 16'(centre), 16'd232);
        tick(0, 1);
        chk("switch_dn", 16'(centre), 16'd234);

        do_reset();
        for (int i = 0; i < 37; i++) tick(1, 0);
        chk("near_top", 16'(centre), 16'd28);
        chk("near_top_flag", 16'(at_top), 16'd0);
        tick(1, 0);
        chk("clamp_top", 16'(centre), 16'd22);
        chk("top_flag", 16'(at_top), 16'd1);
        tick(1, 0);
        tick(1, 0);
        chk("hold_top", 16'(centre), 16'd22);
        chk("hold_top_flag", 16'(at_top), 16'd1);

        for (int i = 0; i < 64; i++) tick(0, 1);
        chk("near_bot", 16'(centre), 16'd450);
        tick(0, 1);
        chk("clamp_bot", 16'(centre), 16'd457);
        chk("bot_flag", 16'(at_bottom), 16'd1);
        tick(0, 1);
        chk("hold_bot", 16'(centre), 16'd457);
        chk("hold_bot_top", 16'(at_top), 16'd0);

        do_reset();
        @(negedge clk) begin up = 0; dn = 0; end
        pix(12'd8, 12'd218, 8'hFF, "pix_tl");
        pix(12'd22, 12'd262, 8'hFF, "pix_br");
        pix(12'd23, 12'd240, 8'h00, "pix_col_out");
        pix(12'd15, 12'd263, 8'h00, "pix_row_out");
        pix(12'd7, 12'd240, 8'h00, "pix_col_lo");
        pix(12'd15, 12'd217, 8'h00, "pix_row_lo");
        pix(12'd15, 12'd240, 8'hFF, "pix_mid");

        @(negedge clk) begin col = 12'd15; row = 12'd240; end
        tick(1, 0);
        chk("mv_centre", 16'(centre), 16'd238);
        pix(12'd15, 12'd261, 8'h00, "pix_new_centre");

        pix(12'd15, 12'd240, 8'hFF, "pre_rst");
        @(posedge clk) #2 reset = 1;
        #1 chk("async_rgb", 16'(rgb), 16'd0);
        chk("async_centre", 16'(centre), 16'd240);
        @(negedge clk) reset = 0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
